axi_lite_rr_arbiter: RTL
========================

AXI_LITE_RR_ARBITER -- requirements
Module: axi_lite_rr_arbiter

Interface
REQ-001 Parameter NUM_M, default 2: number of masters, legal range 2..4.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 Parameter DATA_W, default 32: data width; byte-strobe width is DATA_W/8.
REQ-004 Per-master buses SHALL be flattened, with master i occupying slice [i*W +: W].
REQ-005 Ports:
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-low.
- m_araddr  in  NUM_M*ADDR_W; m_arvalid  in  NUM_M; m_arready  out  NUM_M.
- m_rdata  out  NUM_M*DATA_W; m_rresp  out  NUM_M*2; m_rvalid  out  NUM_M; m_rready  in  NUM_M.
- m_awaddr  in  NUM_M*ADDR_W; m_awvalid  in  NUM_M; m_awready  out  NUM_M.
- m_wdata  in  NUM_M*DATA_W; m_wstrb  in  NUM_M*DATA_W/8; m_wvalid  in  NUM_M; m_wready  out  NUM_M.
- m_bresp  out  NUM_M*2; m_bvalid  out  NUM_M; m_bready  in  NUM_M.
- s_araddr, s_arvalid, s_arready(in), s_rdata(in), s_rresp(in), s_rvalid(in), s_rready: slave read channel, same widths per field.
- s_awaddr, s_awvalid, s_awready(in), s_wdata, s_wstrb, s_wvalid, s_wready(in), s_bresp(in), s_bvalid(in), s_bready: slave write channel.
- grant_o  out  NUM_M  one-hot owner of the slave, zero when idle.

Function
REQ-006 Master i SHALL request when m_arvalid[i]=1, or when m_awvalid[i]=1 and m_wvalid[i]=1.
REQ-007 The FSM SHALL have states IDLE, RD_ADDR, RD_DATA, WR_XFER and WR_RESP, exactly one of which is active at a time.
REQ-008 In IDLE with any request, the FSM SHALL select the first requester at or after priority pointer ptr, wrapping modulo NUM_M, register it in grant_o, and move next cycle to RD_ADDR if its arvalid=1, otherwise to WR_XFER.
- Read has priority over write for the same master.
REQ-009 The request-to-slave latency SHALL be one cycle: a request sampled in IDLE at edge N drives s_*valid from cycle N+1.
REQ-010 RD_ADDR: s_ar* SHALL mirror the granted master and m_arready[g] SHALL equal s_arready; on s_arvalid and s_arready -> RD_DATA.
REQ-011 RD_DATA: s_rdata, s_rresp and s_rvalid SHALL route to master g, and s_rready SHALL equal m_rready[g]; on s_rvalid and s_rready -> IDLE.
REQ-012 WR_XFER: the AW and W channels SHALL be forwarded independently.
- Sticky flags aw_done and w_done are set on each channel's handshake.
- A channel's valid SHALL be masked once its flag is set.
- When both flags are set, or are set in the same cycle, -> WR_RESP.
REQ-013 WR_RESP: the B channel SHALL route to master g; on s_bvalid and s_bready -> IDLE, and the flags SHALL be cleared.
REQ-014 On return to IDLE, ptr SHALL become (g+1) mod NUM_M and grant_o SHALL become 0.
- At least one IDLE cycle SHALL occur between transactions.
REQ-015 Non-granted masters SHALL see arready, rvalid, awready, wready and bvalid equal to 0, and rdata, rresp and bresp equal to 0.
REQ-016 When not in the matching phase, the slave-side valid and ready outputs SHALL be 0 and the address and data outputs SHALL be 0.
REQ-017 Requests that arrive or are withdrawn during a transaction SHALL NOT alter grant_o until IDLE.
REQ-018 Any state other than the five listed SHALL go to IDLE.

Reset
REQ-019 rst=0 SHALL asynchronously force the following, including mid-transaction:
- state = IDLE, ptr = 0, grant_o = 0, aw_done = w_done = 0.
- All valid and ready outputs = 0.
REQ-020 After rst rises, the first arbitration SHALL occur at the first clk edge with a request.

Verification
REQ-021 Single read: NUM_M=2, m_arvalid=01, araddr=0x8000_0000, s_arready=1, s_rvalid next cycle with rdata=0xDEADBEEF -> grant_o=01, m_rdata[0]=0xDEADBEEF, m_rvalid=01 for one cycle, then IDLE.
REQ-022 Round-robin: NUM_M=4, all masters hold arvalid -> grant order 0,1,2,3,0 with exactly one grant per transaction.
REQ-023 Split write: awready=1 in cycle 1 and wready=1 in cycle 3 -> s_awvalid drops after cycle 1, s_wvalid held until cycle 3, then WR_RESP; bresp=2'b10 delivered only to the granted master.
REQ-024 Same-master read and write pending -> read is served first, then the write on a later arbitration.
REQ-025 Reset asserted during RD_DATA -> all outputs 0 immediately (before the next clk edge), ptr=0; a master-1 request after release -> grant_o=10.
REQ-026 Backpressure: s_rvalid=1 with m_rready[g]=0 for 3 cycles -> state stays RD_DATA and rdata is stable; completes on the cycle m_rready rises.

Source files
------------

// File: rtl/axi_lite_rr_arbiter.sv
// rtl/axi_lite_rr_arbiter.sv - round-robin arbiter sharing one AXI-Lite slave among NUM_M masters
module axi_lite_rr_arbiter #(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_M*ADDR_W-1:0]     m_araddr,
  input  logic [NUM_M-1:0]            m_arvalid,
  output logic [NUM_M-1:0]            m_arready,
  output logic [NUM_M*DATA_W-1:0]     m_rdata,
  output logic [NUM_M*2-1:0]          m_rresp,
  output logic [NUM_M-1:0]            m_rvalid,
  input  logic [NUM_M-1:0]            m_rready,
  input  logic [NUM_M*ADDR_W-1:0]     m_awaddr,
  input  logic [NUM_M-1:0]            m_awvalid,
  output logic [NUM_M-1:0]            m_awready,
  input  logic [NUM_M*DATA_W-1:0]     m_wdata,
  input  logic [NUM_M*DATA_W/8-1:0]   m_wstrb,
  input  logic [NUM_M-1:0]            m_wvalid,
  output logic [NUM_M-1:0]            m_wready,
  output logic [NUM_M*2-1:0]          m_bresp,
  output logic [NUM_M-1:0]            m_bvalid,
  input  logic [NUM_M-1:0]            m_bready,
  output logic [ADDR_W-1:0]           s_araddr,
  output logic                        s_arvalid,
  input  logic                        s_arready,
  input  logic [DATA_W-1:0]           s_rdata,
  input  logic [1:0]                  s_rresp,
  input  logic                        s_rvalid,
  output logic                        s_rready,
  output logic [ADDR_W-1:0]           s_awaddr,
  output logic                        s_awvalid,
  input  logic                        s_awready,
  output logic [DATA_W-1:0]           s_wdata,
  output logic [DATA_W/8-1:0]         s_wstrb,
  output logic                        s_wvalid,
  input  logic                        s_wready,
  input  logic [1:0]                  s_bresp,
  input  logic                        s_bvalid,
  output logic                        s_bready,
  output logic [NUM_M-1:0]            grant_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PW     = $clog2(NUM_M);
  localparam logic [PW-1:0] LAST = PW'(NUM_M - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_XFER = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    ptr, ptr_nxt, gidx, gidx_nxt, sel, cand;
  logic [NUM_M-1:0] req, grant_nxt;
  logic             found;
  logic             aw_done, aw_done_nxt, w_done, w_done_nxt;
  logic             aw_hs, w_hs;
  logic [PW-1:0]    ptr_wrap;
  int               idx;

  assign req      = m_arvalid | (m_awvalid & m_wvalid);
  assign ptr_wrap = (gidx == LAST) ? '0 : gidx + 1'b1;

  // First requester at or after ptr, wrapping.
  always_comb begin
    sel   = ptr;
    cand  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_M; k++) begin
      idx  = (int'(ptr) + k) % NUM_M;
      cand = PW'(idx);
      if (!found && req[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    gidx_nxt    = gidx;
    grant_nxt   = grant_o;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    aw_hs       = 1'b0;
    w_hs        = 1'b0;
    m_arready   = '0;
    m_rdata     = '0;
    m_rresp     = '0;
    m_rvalid    = '0;
    m_awready   = '0;
    m_wready    = '0;
    m_bresp     = '0;
    m_bvalid    = '0;
    s_araddr    = '0;
    s_arvalid   = 1'b0;
    s_rready    = 1'b0;
    s_awaddr    = '0;
    s_awvalid   = 1'b0;
    s_wdata     = '0;
    s_wstrb     = '0;
    s_wvalid    = 1'b0;
    s_bready    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt      = '0;
          grant_nxt[sel] = 1'b1;
          gidx_nxt       = sel;
          state_nxt      = m_arvalid[sel] ? RD_ADDR : WR_XFER;
        end
      end
      RD_ADDR: begin
        for (int i = 0; i < NUM_M; i++) begin
          if (grant_o[i]) begin
            s_araddr     = m_araddr[i*ADDR_W +: ADDR_W];
            s_arvalid    = m_arvalid[i];
            m_arready[i] = s_arready;
          end
        end
        if (s_arvalid && s_arready) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        for (int i = 0; i < NUM_M; i++) begin
          if (grant_o[i]) begin
            m_rdata[i*DATA_W +: DATA_W] = s_rdata;
            m_rresp[i*2 +: 2]           = s_rresp;
            m_rvalid[i]                 = s_rvalid;
            s_rready                    = m_rready[i];
          end
        end
        if (s_rvalid && s_rready) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          ptr_nxt   = ptr_wrap;
        end
      end
      WR_XFER: begin
        // Each channel's valid/ready is masked once its own handshake is done.
        for (int i = 0; i < NUM_M; i++) begin
          if (grant_o[i]) begin
            s_awaddr     = m_awaddr[i*ADDR_W +: ADDR_W];
            s_awvalid    = m_awvalid[i] & ~aw_done;
            m_awready[i] = s_awready & ~aw_done;
            s_wdata      = m_wdata[i*DATA_W +: DATA_W];
            s_wstrb      = m_wstrb[i*STRB_W +: STRB_W];
            s_wvalid     = m_wvalid[i] & ~w_done;
            m_wready[i]  = s_wready & ~w_done;
          end
        end
        aw_hs = s_awvalid & s_awready;
        w_hs  = s_wvalid & s_wready;
        if (aw_hs) aw_done_nxt = 1'b1;
        if (w_hs)  w_done_nxt  = 1'b1;
        if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        for (int i = 0; i < NUM_M; i++) begin
          if (grant_o[i]) begin
            m_bresp[i*2 +: 2] = s_bresp;
            m_bvalid[i]       = s_bvalid;
            s_bready          = m_bready[i];
          end
        end
        if (s_bvalid && s_bready) begin
          state_nxt   = IDLE;
          grant_nxt   = '0;
          ptr_nxt     = ptr_wrap;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt   = IDLE;
        grant_nxt   = '0;
        aw_done_nxt = 1'b0;
        w_done_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gidx    <= '0;
      grant_o <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gidx    <= gidx_nxt;
      grant_o <= grant_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
    end
  end

endmodule
